// File: rtl/mem_responder.sv
// Data-port memory responder: accepts one load/store at a time, waits LATENCY cycles,
// applies byte-lane writes or extended reads, and answers with a one-cycle READY pulse.
module mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        REQ_i,
    input  logic        WE_i,
    input  logic [31:0] ADDR_i,
    input  logic [3:0]  BE_i,
    input  logic [2:0]  FUNCT3_i,
    input  logic [31:0] WDATA_i,
    output logic [31:0] RDATA_o,
    output logic        READY_o,
    output logic        BUSY_o,
    output logic        ERR_o
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
    localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] wdata_q, wdata_d;

    logic        ready_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic [31:0] mem_array [DEPTH];

    // With LATENCY=0 the RESP-entry edge is the acceptance edge itself, so the
    // access is evaluated on the live inputs in IDLE and on the captured copy otherwise.
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [3:0]  cur_be;
    logic [2:0]  cur_f3;
    logic [31:0] cur_wdata;

    logic        enter_resp;
    logic [1:0]  cur_off;
    logic [AW-1:0] mem_idx;
    logic        in_range;
    logic        be_ok;
    logic        f3_ok;
    logic        acc_err;
    logic [3:0]  lane_mask;
    logic [31:0] wdata_sh;
    logic [31:0] rd_word;
    logic [31:0] rd_sh;
    logic [31:0] load_val;
    logic [31:0] rdata_next;
    logic        do_write;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (REQ_i) begin
                    we_d    = WE_i;
                    addr_d  = ADDR_i;
                    be_d    = BE_i;
                    f3_d    = FUNCT3_i;
                    wdata_d = WDATA_i;
                    if (LATENCY > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_we    = WE_i;
            cur_addr  = ADDR_i;
            cur_be    = BE_i;
            cur_f3    = FUNCT3_i;
            cur_wdata = WDATA_i;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_be    = be_q;
            cur_f3    = f3_q;
            cur_wdata = wdata_q;
        end
    end

    assign enter_resp = (state_d == ST_RESP);

    // ------------------------------------------------------------------
    // Access decode and error detection
    // ------------------------------------------------------------------
    assign cur_off   = cur_addr[1:0];
    assign mem_idx   = cur_addr[AW+1:2];
    assign in_range  = (cur_addr[31:2] < DEPTH_W);
    assign lane_mask = cur_be << cur_off;
    assign wdata_sh  = cur_wdata << {cur_off, 3'b000};

    always_comb begin
        be_ok = 1'b0;
        case (cur_be)
            4'b0001: be_ok = 1'b1;
            4'b0011: be_ok = ~cur_addr[0];
            4'b1111: be_ok = (cur_off == 2'b00);
            default: be_ok = 1'b0;
        endcase
    end

    always_comb begin
        f3_ok = 1'b0;
        case (cur_f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
            default:                                f3_ok = 1'b0;
        endcase
        if (cur_we) begin
            f3_ok = 1'b1;
        end
    end

    assign acc_err = ~be_ok | ~in_range | ~f3_ok;

    // ------------------------------------------------------------------
    // Load path: shift the addressed lane down, then extend
    // ------------------------------------------------------------------
    assign rd_word = mem_array[mem_idx];
    assign rd_sh   = rd_word >> {cur_off, 3'b000};

    always_comb begin
        load_val = 32'd0;
        case (cur_f3)
            3'b000:  load_val = {{24{rd_sh[7]}}, rd_sh[7:0]};
            3'b100:  load_val = {24'd0, rd_sh[7:0]};
            3'b001:  load_val = {{16{rd_sh[15]}}, rd_sh[15:0]};
            3'b101:  load_val = {16'd0, rd_sh[15:0]};
            3'b010:  load_val = rd_sh;
            default: load_val = 32'd0;
        endcase
    end

    assign rdata_next = (acc_err || cur_we) ? 32'd0 : load_val;
    assign do_write   = RSTn && enter_resp && cur_we && !acc_err;

    // ------------------------------------------------------------------
    // Storage: byte-lane writes, contents never reset
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask[i]) begin
                    mem_array[mem_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            f3_q    <= 3'd0;
            wdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            ready_q <= enter_resp;
            err_q   <= enter_resp && acc_err;
            rdata_q <= enter_resp ? rdata_next : 32'd0;
        end
    end

    assign READY_o = ready_q;
    assign ERR_o   = err_q;
    assign RDATA_o = rdata_q;
    assign BUSY_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed checks of mem_responder against a byte-array reference model,
// using one LATENCY=2 instance and one LATENCY=0 instance with a small DEPTH.
module tb_mem_responder;

    localparam int DA = 1024;
    localparam int LA = 2;
    localparam int DB = 16;
    localparam int LB = 0;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        req_a, req_b;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [2:0]  f3;
    logic [31:0] wdata;

    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b, busy_a, busy_b, err_a, err_b;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem_a [DA*4];
    logic [7:0] mem_b [DB*4];

    always #5 CLK = ~CLK;

    mem_responder #(.DEPTH(DA), .LATENCY(LA)) dut_a (
        .CLK(CLK), .RSTn(RSTn), .REQ_i(req_a), .WE_i(we), .ADDR_i(addr), .BE_i(be),
        .FUNCT3_i(f3), .WDATA_i(wdata), .RDATA_o(rdata_a), .READY_o(ready_a),
        .BUSY_o(busy_a), .ERR_o(err_a)
    );

    mem_responder #(.DEPTH(DB), .LATENCY(LB)) dut_b (
        .CLK(CLK), .RSTn(RSTn), .REQ_i(req_b), .WE_i(we), .ADDR_i(addr), .BE_i(be),
        .FUNCT3_i(f3), .WDATA_i(wdata), .RDATA_o(rdata_b), .READY_o(ready_b),
        .BUSY_o(busy_b), .ERR_o(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_err(input bit w, input logic [31:0] a, input logic [3:0] b,
                                   input logic [2:0] f, input int depth);
        bit e = 1'b0;
        if (!(b == 4'b0001 || b == 4'b0011 || b == 4'b1111)) e = 1'b1;
        if (b == 4'b0011 && a[0]) e = 1'b1;
        if (b == 4'b1111 && a[1:0] != 2'b00) e = 1'b1;
        if ({2'b00, a[31:2]} >= 32'(depth)) e = 1'b1;
        if (!w && !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) e = 1'b1;
        return e;
    endfunction

    // Expected load value built byte by byte from the addressed location upward.
    function automatic logic [31:0] ref_load(input bit sel, input logic [31:0] a, input logic [2:0] f);
        logic [31:0] v = 32'd0;
        int nb;
        int base = int'(a);
        nb = (f[1:0] == 2'd0) ? 1 : ((f[1:0] == 2'd1) ? 2 : 4);
        for (int k = 0; k < nb; k++) begin
            if (int'(a[1:0]) + k < 4) v[8*k +: 8] = sel ? mem_b[base + k] : mem_a[base + k];
        end
        if (!f[2] && nb < 4 && v[8*nb - 1]) v = v | (32'hFFFF_FFFF << (8*nb));
        return v;
    endfunction

    // Issue one request at a negedge; returns at the negedge after the READY cycle.
    task automatic op(input bit sel, input bit w, input logic [31:0] a, input logic [3:0] b,
                      input logic [2:0] f, input logic [31:0] wd, output logic [31:0] rd);
        int          lat = sel ? LB : LA;
        bit          e   = ref_err(w, a, b, f, sel ? DB : DA);
        logic [31:0] exp_rd;
        int          n = 0;
        bit          seen = 1'b0;
        exp_rd = (w || e) ? 32'd0 : ref_load(sel, a, f);
        we = w; addr = a; be = b; f3 = f; wdata = wd;
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        @(posedge CLK);
        while (!seen && n < 40) begin
            @(negedge CLK);
            n++;
            seen = sel ? ready_b : ready_a;
        end
        req_a = 1'b0;
        req_b = 1'b0;
        rd = sel ? rdata_b : rdata_a;
        chk("latency", 32'(n), 32'(lat + 1));
        chk("err", {31'd0, sel ? err_b : err_a}, {31'd0, e});
        chk("rdata", rd, exp_rd);
        chk("busy_resp", {31'd0, sel ? busy_b : busy_a}, 32'd1);
        @(negedge CLK);
        chk("ready_pulse", {31'd0, sel ? ready_b : ready_a}, 32'd0);
        chk("busy_idle", {31'd0, sel ? busy_b : busy_a}, 32'd0);
        if (w && !e) begin
            for (int k = 0; k < 4; k++) begin
                if (b[k]) begin
                    if (sel) mem_b[int'(a) + k] = wd[8*k +: 8];
                    else     mem_a[int'(a) + k] = wd[8*k +: 8];
                end
            end
        end
        $display("txn dut=%s we=%0d addr=%h be=%b f3=%0d wdata=%h rdata=%h err=%0d",
                 sel ? "b" : "a", w, a, b, f, wd, rd, e);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] old_word;
        logic [31:0] ra;
        logic [3:0]  rb;
        logic [2:0]  rf;

        RSTn = 1'b0; req_a = 1'b0; req_b = 1'b0;
        we = 1'b0; addr = 32'd0; be = 4'd0; f3 = 3'd0; wdata = 32'd0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ready_a", {31'd0, ready_a}, 32'd0);
        chk("rst_busy_a",  {31'd0, busy_a},  32'd0);
        chk("rst_err_a",   {31'd0, err_a},   32'd0);
        chk("rst_rdata_a", rdata_a, 32'd0);
        chk("rst_ready_b", {31'd0, ready_b}, 32'd0);
        chk("rst_rdata_b", rdata_b, 32'd0);
        RSTn = 1'b1;
        @(negedge CLK);

        // Initialize the region used by random traffic so the model is fully defined.
        for (int i = 0; i < 64; i++) op(1'b0, 1'b1, 32'(4*i), 4'b1111, 3'd2, $urandom, rd);
        for (int i = 0; i < DB; i++) op(1'b1, 1'b1, 32'(4*i), 4'b1111, 3'd2, $urandom, rd);

        // Word round trip
        op(1'b0, 1'b1, 32'h10, 4'b1111, 3'd2, 32'hDEADBEEF, rd);
        op(1'b0, 1'b0, 32'h10, 4'b1111, 3'd2, 32'd0, rd);
        chk("word_rt", rd, 32'hDEADBEEF);

        // Byte lane and extension
        op(1'b0, 1'b1, 32'h10, 4'b1111, 3'd2, 32'h0, rd);
        op(1'b0, 1'b1, 32'h13, 4'b0001, 3'd0, 32'h80, rd);
        op(1'b0, 1'b0, 32'h10, 4'b1111, 3'd2, 32'd0, rd);
        chk("byte_word", rd, 32'h80000000);
        op(1'b0, 1'b0, 32'h13, 4'b0001, 3'd0, 32'd0, rd);
        chk("lb", rd, 32'hFFFFFF80);
        op(1'b0, 1'b0, 32'h13, 4'b0001, 3'd4, 32'd0, rd);
        chk("lbu", rd, 32'h00000080);

        // Halfword
        op(1'b0, 1'b1, 32'h20, 4'b1111, 3'd2, 32'h1234ABCD, rd);
        op(1'b0, 1'b1, 32'h22, 4'b0011, 3'd1, 32'h8001, rd);
        op(1'b0, 1'b0, 32'h22, 4'b0011, 3'd1, 32'd0, rd);
        chk("lh", rd, 32'hFFFF8001);
        op(1'b0, 1'b0, 32'h22, 4'b0011, 3'd5, 32'd0, rd);
        chk("lhu", rd, 32'h00008001);
        op(1'b0, 1'b0, 32'h20, 4'b0011, 3'd5, 32'd0, rd);
        chk("half_low_kept", rd, 32'h0000ABCD);

        // Error cases, each followed by a read-back of the touched word
        op(1'b0, 1'b1, 32'h02, 4'b1111, 3'd2, 32'h11111111, rd);
        op(1'b0, 1'b1, 32'h01, 4'b0011, 3'd1, 32'h2222, rd);
        op(1'b0, 1'b1, 32'h00, 4'b0101, 3'd2, 32'h33333333, rd);
        op(1'b0, 1'b1, 32'(DA*4), 4'b1111, 3'd2, 32'h44444444, rd);
        op(1'b0, 1'b0, 32'(DA*4), 4'b1111, 3'd2, 32'd0, rd);
        op(1'b0, 1'b0, 32'h00, 4'b1111, 3'd2, 32'd0, rd);
        op(1'b0, 1'b0, 32'h00, 4'b1111, 3'd3, 32'd0, rd);
        op(1'b1, 1'b1, 32'(DB*4), 4'b1111, 3'd2, 32'h55555555, rd);
        op(1'b1, 1'b0, 32'h00, 4'b1111, 3'd2, 32'd0, rd);

        // Randomized traffic on the LATENCY=2 instance
        for (int i = 0; i < 150; i++) begin
            ra = ($urandom % 8 == 0) ? 32'(DA*4) + 32'($urandom % 64) : 32'($urandom % 256);
            case ($urandom % 4)
                0:       rb = 4'b0001;
                1:       rb = 4'b0011;
                2:       rb = 4'b1111;
                default: rb = 4'($urandom);
            endcase
            case ($urandom % 6)
                0:       rf = 3'd0;
                1:       rf = 3'd1;
                2:       rf = 3'd2;
                3:       rf = 3'd4;
                4:       rf = 3'd5;
                default: rf = 3'($urandom);
            endcase
            op(1'b0, 1'($urandom), ra, rb, rf, $urandom, rd);
        end

        // LATENCY=0: REQ held through RESP is only re-accepted in the following IDLE cycle
        op(1'b1, 1'b1, 32'h0C, 4'b1111, 3'd2, 32'h12345678, rd);
        we = 1'b0; addr = 32'h0C; be = 4'b1111; f3 = 3'd2; req_b = 1'b1;
        @(negedge CLK);
        chk("b2b_ready1", {31'd0, ready_b}, 32'd1);
        chk("b2b_rdata1", rdata_b, 32'h12345678);
        @(negedge CLK);
        chk("b2b_ready_gap", {31'd0, ready_b}, 32'd0);
        chk("b2b_busy_gap", {31'd0, busy_b}, 32'd0);
        @(negedge CLK);
        chk("b2b_ready2", {31'd0, ready_b}, 32'd1);
        chk("b2b_rdata2", rdata_b, 32'h12345678);
        req_b = 1'b0;
        @(negedge CLK);
        chk("b2b_ready_end", {31'd0, ready_b}, 32'd0);
        $display("txn dut=b back-to-back load addr=0000000c");

        // Reset during WAIT drops a pending store
        old_word = {mem_a[16+3], mem_a[16+2], mem_a[16+1], mem_a[16]};
        we = 1'b1; addr = 32'h10; be = 4'b1111; f3 = 3'd2; wdata = 32'hCAFEF00D; req_a = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("wait_busy", {31'd0, busy_a}, 32'd1);
        RSTn = 1'b0;
        req_a = 1'b0;
        @(negedge CLK);
        chk("mid_rst_ready", {31'd0, ready_a}, 32'd0);
        chk("mid_rst_busy",  {31'd0, busy_a},  32'd0);
        chk("mid_rst_err",   {31'd0, err_a},   32'd0);
        chk("mid_rst_rdata", rdata_a, 32'd0);
        RSTn = 1'b1;
        $display("txn dut=a store dropped by reset addr=00000010");
        @(negedge CLK);
        op(1'b0, 1'b0, 32'h10, 4'b1111, 3'd2, 32'd0, rd);
        chk("rst_store_dropped", rd, old_word);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
